// File: rtl/c7bbiu_rd_ret_pkg.sv
// ----------------------------------------------------------------------------
// c7bbiu_rd_ret_pkg
//   Shared AXI constants and state encoding for the c7bbiu read-return path.
//   - AXI_RID_*  : read IDs assigned to the IFU, LSU and ICU requesters
//   - AXI_RESP_* : AXI response encodings
//   - rdret_state_e : read-return FSM states
// ----------------------------------------------------------------------------
package c7bbiu_rd_ret_pkg;

    localparam logic [7:0] AXI_RID_IFU = 8'd0;
    localparam logic [7:0] AXI_RID_LSU = 8'd1;
    localparam logic [7:0] AXI_RID_ICU = 8'd2;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        RDRET_IDLE = 2'd0,
        RDRET_WAIT = 2'd1,
        RDRET_DATA = 2'd2
    } rdret_state_e;

    // SLVERR and DECERR both have resp[1] set.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
    endfunction

endpackage

// File: rtl/c7bbiu_rd_ret_dp.sv
// ----------------------------------------------------------------------------
// c7bbiu_rd_ret_dp
//   Output register stage of the read-return path. Every output is the
//   registered image of the beat accepted in the previous cycle.
//   Ports:
//     clk, rst_l          clock, synchronous active-low reset
//     acc_i               beat accepted this cycle
//     hit_ifu/lsu/icu_i   RID decode of the accepted beat
//     r_data_i/resp/last  beat payload
//     beat_i              low bits of the beat counter
//     *_o                 registered outputs (see top-level header)
// ----------------------------------------------------------------------------
module c7bbiu_rd_ret_dp
    import c7bbiu_rd_ret_pkg::*;
#(
    parameter int unsigned DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic              acc_i,
    input  logic              hit_ifu_i,
    input  logic              hit_lsu_i,
    input  logic              hit_icu_i,
    input  logic [DATA_W-1:0] r_data_i,
    input  logic [1:0]        r_resp_i,
    input  logic              r_last_i,
    input  logic [1:0]        beat_i,
    output logic              ifu_val_o,
    output logic              lsu_val_o,
    output logic              icu_val_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic [1:0]        icu_beat_o,
    output logic              icu_last_o,
    output logic              rd_err_o,
    output logic              rd_done_o
);

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            ifu_val_o  <= 1'b0;
            lsu_val_o  <= 1'b0;
            icu_val_o  <= 1'b0;
            rd_data_o  <= '0;
            icu_beat_o <= '0;
            icu_last_o <= 1'b0;
            rd_err_o   <= 1'b0;
            rd_done_o  <= 1'b0;
        end else begin
            // Data holds the last beat; the sideband flops are pulses.
            if (acc_i) begin
                rd_data_o <= r_data_i;
            end
            ifu_val_o  <= acc_i & hit_ifu_i;
            lsu_val_o  <= acc_i & hit_lsu_i;
            icu_val_o  <= acc_i & hit_icu_i;
            icu_beat_o <= acc_i ? beat_i : 2'b00;
            icu_last_o <= acc_i & hit_icu_i & r_last_i;
            rd_err_o   <= acc_i & resp_is_err(r_resp_i);
            rd_done_o  <= acc_i & r_last_i;
        end
    end

endmodule

// File: rtl/c7bbiu_rd_ret.sv
// ----------------------------------------------------------------------------
// c7bbiu_rd_ret
//   AXI read-data return stage. Tracks the single outstanding read issued by
//   the arbiter, accepts R beats and routes each one by RID to the IFU, LSU or
//   ICU with one registered cycle of latency.
//   Ports:
//     clk, resetn                  clock, synchronous active-low reset
//     arb_rd_val/id/len            read issued by the arbiter
//     ext_biu_r_*                  AXI R channel in, biu_ext_r_ready out
//     biu_ifu/lsu_rd_val, biu_icu_val   per-requester beat valid pulses
//     biu_rd_data                  registered beat data
//     biu_icu_beat, biu_icu_last   ICU burst beat index / final beat
//     biu_rd_err                   SLVERR/DECERR on the delivered beat
//     biu_rd_done                  last beat delivered
//   Optional: define C7BBIU_RD_RET_CHK_EN to add biu_rd_proto_err, a sticky
//   protocol-violation flag (RID mismatch, early/missing last, issue while busy).
// ----------------------------------------------------------------------------
module c7bbiu_rd_ret
    import c7bbiu_rd_ret_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              arb_rd_val,
    input  logic [ID_W-1:0]   arb_rd_id,
    input  logic [7:0]        arb_rd_len,
    input  logic              ext_biu_r_valid,
    input  logic [ID_W-1:0]   ext_biu_r_id,
    input  logic [DATA_W-1:0] ext_biu_r_data,
    input  logic [1:0]        ext_biu_r_resp,
    input  logic              ext_biu_r_last,
    output logic              biu_ext_r_ready,
    output logic              biu_ifu_rd_val,
    output logic              biu_lsu_rd_val,
    output logic              biu_icu_val,
    output logic [DATA_W-1:0] biu_rd_data,
    output logic [1:0]        biu_icu_beat,
    output logic              biu_icu_last,
    output logic              biu_rd_err,
    output logic              biu_rd_done
`ifdef C7BBIU_RD_RET_CHK_EN
   ,output logic              biu_rd_proto_err
`endif
);

    rdret_state_e state_q;
    logic [7:0]   beat_cnt_q;
    logic         acc;
    logic         hit_ifu, hit_lsu, hit_icu;

    // Ready is a registered FSM output: high exactly in WAIT and DATA.
    assign acc = ext_biu_r_valid & biu_ext_r_ready;

    assign hit_ifu = (ext_biu_r_id == ID_W'(AXI_RID_IFU));
    assign hit_lsu = (ext_biu_r_id == ID_W'(AXI_RID_LSU));
    assign hit_icu = (ext_biu_r_id == ID_W'(AXI_RID_ICU));

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q         <= RDRET_IDLE;
            biu_ext_r_ready <= 1'b0;
            beat_cnt_q      <= '0;
        end else begin
            case (state_q)
                RDRET_IDLE: begin
                    if (arb_rd_val) begin
                        state_q         <= RDRET_WAIT;
                        biu_ext_r_ready <= 1'b1;
                        beat_cnt_q      <= '0;
                    end
                end
                RDRET_WAIT, RDRET_DATA: begin
                    if (acc) begin
                        if (ext_biu_r_last) begin
                            state_q         <= RDRET_IDLE;
                            biu_ext_r_ready <= 1'b0;
                            beat_cnt_q      <= '0;
                        end else begin
                            state_q    <= RDRET_DATA;
                            beat_cnt_q <= beat_cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q         <= RDRET_IDLE;
                    biu_ext_r_ready <= 1'b0;
                end
            endcase
        end
    end

`ifdef C7BBIU_RD_RET_CHK_EN
    // The captured ID/len only feed the checker, so they exist in this build only.
    logic [ID_W-1:0] out_id_q;
    logic [7:0]      out_len_q;
    logic            proto_set;

    always_comb begin
        proto_set = 1'b0;
        if (acc) begin
            proto_set = (ext_biu_r_id != out_id_q)
                      | ( ext_biu_r_last & (beat_cnt_q != out_len_q))
                      | (!ext_biu_r_last & (beat_cnt_q == out_len_q));
        end
        if (arb_rd_val && (state_q != RDRET_IDLE)) begin
            proto_set = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_id_q         <= '0;
            out_len_q        <= '0;
            biu_rd_proto_err <= 1'b0;
        end else begin
            if ((state_q == RDRET_IDLE) && arb_rd_val) begin
                out_id_q  <= arb_rd_id;
                out_len_q <= arb_rd_len;
            end
            biu_rd_proto_err <= biu_rd_proto_err | proto_set;
        end
    end
`endif

    c7bbiu_rd_ret_dp #(
        .DATA_W (DATA_W)
    ) u_dp (
        .clk        (clk),
        .rst_l      (resetn),
        .acc_i      (acc),
        .hit_ifu_i  (hit_ifu),
        .hit_lsu_i  (hit_lsu),
        .hit_icu_i  (hit_icu),
        .r_data_i   (ext_biu_r_data),
        .r_resp_i   (ext_biu_r_resp),
        .r_last_i   (ext_biu_r_last),
        .beat_i     (beat_cnt_q[1:0]),
        .ifu_val_o  (biu_ifu_rd_val),
        .lsu_val_o  (biu_lsu_rd_val),
        .icu_val_o  (biu_icu_val),
        .rd_data_o  (biu_rd_data),
        .icu_beat_o (biu_icu_beat),
        .icu_last_o (biu_icu_last),
        .rd_err_o   (biu_rd_err),
        .rd_done_o  (biu_rd_done)
    );

`ifndef C7BBIU_RD_RET_CHK_EN
    // arb_rd_id/arb_rd_len are only consumed by the checker build.
    logic unused_arb;
    assign unused_arb = ^{arb_rd_id, arb_rd_len};
`endif

endmodule
